// File: rtl/rs232_transmitter_pkg.sv
// rtl/rs232_transmitter_pkg.sv - shared encodings and helpers for the RS232 serial blocks
package rs232_transmitter_pkg;

    // Frame sequencer states, shared with the receiver side
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per bit period; truncating division, result must be >= 2
    function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/rs232_transmitter_baud_generator.sv
// rtl/rs232_transmitter_baud_generator.sv - free-running bit-period tick generator with realign
module baud_generator #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic clear_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = $clog2(DIV * 2);

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; restart forces the next cycle to be count 0
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == CW'(DIV - 1))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bit_tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/rs232_transmitter.sv
// rtl/rs232_transmitter.sv - fifo-fed RS232 frame transmitter (start/data/parity/stop)
module rs232_transmitter
    import rs232_transmitter_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop_clock,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int DIV      = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW       = $clog2(DIV * 2);
    localparam int STOP_LEN = STOP_BITS * DIV;

    tx_state_t              r_state;
    logic                   r_tx;
    logic                   r_pop;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pop_cnt;
    logic [2:0]             r_bit_cnt;
    logic [CW-1:0]          r_stop_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;

    logic                   w_bit_tick;
    logic                   w_restart;

    // Realign the bit clock while loading so START gets a full DIV-cycle period
    assign w_restart = (r_state == ST_LOAD);

    baud_generator #(
        .DIV (DIV)
    ) u_baud_generator (
        .clk      (clk),
        .clear_n  (clear_n),
        .restart  (w_restart),
        .bit_tick (w_bit_tick)
    );

    // Frame sequencer; tx/pop/busy/byte_done are set alongside the state they belong to
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_pop      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pop_cnt  <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        r_state   <= ST_POP;
                        r_pop     <= 1'b1;
                        r_pop_cnt <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_POP: begin
                    if (r_pop_cnt) begin
                        r_state <= ST_LOAD;
                        r_pop   <= 1'b0;
                    end else begin
                        r_pop_cnt <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_shift  <= fifo_data[DATA_BITS-1:0];
                    r_parity <= (PARITY == PARITY_ODD) ? ~^fifo_data[DATA_BITS-1:0]
                                                       : ^fifo_data[DATA_BITS-1:0];
                    r_state  <= ST_START;
                    r_tx     <= 1'b0;
                end
                ST_START: begin
                    if (w_bit_tick) begin
                        r_state   <= ST_DATA;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            if (PARITY != PARITY_NONE) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state    <= ST_STOP;
                                r_tx       <= 1'b1;
                                r_stop_cnt <= '0;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_state    <= ST_STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    // Stop length is counted directly so byte_done lands in the last cycle
                    if (r_stop_cnt == CW'(STOP_LEN - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_stop_cnt <= r_stop_cnt + CW'(1);
                        if (r_stop_cnt == CW'(STOP_LEN - 2)) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_pop   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx             = r_tx;
    assign fifo_pop_clock = r_pop;
    assign busy           = r_busy;
    assign byte_done      = r_done;

endmodule

// File: tb/tb_rs232_transmitter.sv
// tb/tb_rs232_transmitter.sv - directed self-checking bench for rs232_transmitter
module tb_rs232_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear_n = 1'b1;
    logic [2:0] en = 3'b000;

    logic [7:0] mem [3][8];
    int         wr [3] = '{0, 0, 0};
    int         rd [3] = '{0, 0, 0};
    int         pops [3] = '{0, 0, 0};
    int         underflow = 0;
    logic [2:0] pop_q = 3'b000;
    logic [7:0] fdata [3];
    logic [2:0] fempty;

    wire  [2:0] tx_w;
    wire  [2:0] busy_w;
    wire  [2:0] pop_w;
    wire  [2:0] done_w;

    int errors = 0;
    int checks = 0;

    // index 0: no parity, 1 stop; index 1: even parity, 1 stop; index 2: odd parity, 2 stops
    rs232_transmitter #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_none (
        .clk(clk), .clear_n(clear_n), .enable(en[0]), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
        .fifo_pop_clock(pop_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .byte_done(done_w[0]));
    rs232_transmitter #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_even (
        .clk(clk), .clear_n(clear_n), .enable(en[1]), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
        .fifo_pop_clock(pop_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .byte_done(done_w[1]));
    rs232_transmitter #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut_odd2 (
        .clk(clk), .clear_n(clear_n), .enable(en[2]), .fifo_empty(fempty[2]), .fifo_data(fdata[2]),
        .fifo_pop_clock(pop_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .byte_done(done_w[2]));

    // fifo model: empty flag straight from pointers
    always_comb begin
        fempty = '0;
        for (int i = 0; i < 3; i++) fempty[i] = (rd[i] == wr[i]);
    end

    // fifo model: each rising pop strobe presents the next byte on out_data
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pop_w[i] && !pop_q[i]) begin
                pops[i] <= pops[i] + 1;
                if (rd[i] == wr[i]) underflow <= underflow + 1;
                else begin
                    fdata[i] <= mem[i][rd[i] % 8];
                    rd[i]    <= rd[i] + 1;
                end
            end
        end
        pop_q <= pop_w;
    end

    task automatic push(input int sel, input logic [7:0] b);
        mem[sel][wr[sel] % 8] = b;
        wr[sel] = wr[sel] + 1;
    endtask

    task automatic frame_check(input int sel, input logic [7:0] b, input int par, input int stops,
                               input int drop_at, input string name);
        logic [11:0] ebits, bad, seen;
        int nb, t, total, done_hits, done_last, busy_bad;
        nb = 0; ebits = '0; bad = '0; seen = '0;
        ebits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin ebits[nb] = b[i]; nb++; end
        if (par >= 0) begin ebits[nb] = par[0]; nb++; end
        for (int s = 0; s < stops; s++) begin ebits[nb] = 1'b1; nb++; end
        t = 0;
        while (tx_w[sel] !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (tx_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s start: tx=%b required 0 within 2000 clocks", name, tx_w[sel]);
        end else begin
            total = nb * 10; done_hits = 0; done_last = 0; busy_bad = 0;
            for (int c = 0; c < total; c++) begin
                if (c == drop_at) en[sel] = 1'b0;
                if (tx_w[sel] !== ebits[c / 10] && !bad[c / 10]) begin
                    bad[c / 10]  = 1'b1;
                    seen[c / 10] = tx_w[sel];
                end
                if (done_w[sel] === 1'b1) begin
                    done_hits++;
                    if (c == total - 1) done_last = 1;
                end
                if (busy_w[sel] !== 1'b1) busy_bad++;
                @(negedge clk);
            end
            for (int k = 0; k < nb; k++) begin
                checks++;
                if (bad[k]) begin
                    errors++;
                    $display("FAIL %s bit %0d: tx=%b required %b for all 10 clocks", name, k, seen[k], ebits[k]);
                end
            end
            checks++;
            if (done_hits !== 1 || done_last !== 1) begin
                errors++;
                $display("FAIL %s byte_done: pulses=%0d at_end=%0d required 1 and 1", name, done_hits, done_last);
            end
            checks++;
            if (busy_bad !== 0) begin
                errors++;
                $display("FAIL %s busy: low for %0d frame clocks required 0", name, busy_bad);
            end
            checks++;
            if (tx_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || done_w[sel] !== 1'b0) begin
                errors++;
                $display("FAIL %s post: tx=%b busy=%b done=%b required 1 0 0", name, tx_w[sel], busy_w[sel], done_w[sel]);
            end
        end
    endtask

    task automatic idle_check(input int sel, input int ncyc, input int exp_pops, input string name);
        int bad;
        bad = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || pop_w[sel] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s idle: %0d bad clocks required 0", name, bad);
        end
        checks++;
        if (pops[sel] !== exp_pops) begin
            errors++;
            $display("FAIL %s pops: got %0d required %0d", name, pops[sel], exp_pops);
        end
    endtask

    task automatic test_reset();
        #1 clear_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || pop_w[i] !== 1'b0 || done_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_%0d: tx=%b busy=%b pop=%b done=%b required 1 0 0 0",
                         i, tx_w[i], busy_w[i], pop_w[i], done_w[i]);
            end
        end
        repeat (3) @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int t, p0;
        push(0, 8'h55);
        en[0] = 1'b1;
        t = 0;
        while (tx_w[0] !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (tx_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset start: tx=%b required 0", tx_w[0]);
        end
        repeat (3) @(negedge clk);
        clear_n = 1'b0;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || pop_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset async: tx=%b busy=%b pop=%b required 1 0 0", tx_w[0], busy_w[0], pop_w[0]);
        end
        @(negedge clk);
        clear_n = 1'b1;
        p0 = pops[0];
        idle_check(0, 1000, p0, "midreset_empty");
        en[0] = 1'b0;
    endtask

    task automatic test_single_frame();
        int t, pw, p0;
        p0 = pops[0];
        push(0, 8'hAC);
        en[0] = 1'b1;
        t = 0; pw = 0;
        while (tx_w[0] !== 1'b0 && t < 200) begin
            @(negedge clk); t++;
            if (pop_w[0] === 1'b1) pw++;
        end
        checks++;
        if (pw !== 2) begin
            errors++;
            $display("FAIL single pop_width: got %0d required 2", pw);
        end
        frame_check(0, 8'hAC, -1, 1, -1, "single");
        idle_check(0, 30, p0 + 1, "single");
        en[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int g, p0;
        p0 = pops[1];
        push(1, 8'hAC);
        push(1, 8'h61);
        en[1] = 1'b1;
        frame_check(1, 8'hAC, 0, 1, -1, "even_a");
        g = 0;
        while (tx_w[1] === 1'b1 && g < 50) begin @(negedge clk); g++; end
        checks++;
        if (g !== 4) begin
            errors++;
            $display("FAIL b2b gap: got %0d clocks required 4", g);
        end
        frame_check(1, 8'h61, 1, 1, -1, "even_b");
        idle_check(1, 40, p0 + 2, "b2b");
        en[1] = 1'b0;
    endtask

    task automatic test_odd_two_stop();
        int p0;
        p0 = pops[2];
        push(2, 8'h61);
        en[2] = 1'b1;
        frame_check(2, 8'h61, 0, 2, -1, "odd_2stop");
        idle_check(2, 20, p0 + 1, "odd_2stop");
        en[2] = 1'b0;
    endtask

    task automatic test_enable_drop();
        int p0;
        p0 = pops[0];
        push(0, 8'h3C);
        push(0, 8'hA5);
        en[0] = 1'b1;
        frame_check(0, 8'h3C, -1, 1, 45, "drop_a");
        idle_check(0, 100, p0 + 1, "drop_hold");
        en[0] = 1'b1;
        frame_check(0, 8'hA5, -1, 1, -1, "drop_b");
        idle_check(0, 20, p0 + 2, "drop_b");
        en[0] = 1'b0;
    endtask

    task automatic test_empty_mid_frame();
        int p0;
        p0 = pops[1];
        push(1, 8'h5A);
        en[1] = 1'b1;
        frame_check(1, 8'h5A, 0, 1, -1, "empty");
        idle_check(1, 50, p0 + 1, "empty");
        en[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_single_frame();
        test_back_to_back();
        test_odd_two_stop();
        test_enable_drop();
        test_empty_mid_frame();
        checks++;
        if (underflow !== 0) begin
            errors++;
            $display("FAIL underflow: pops while empty=%0d required 0", underflow);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
